// File: rtl/hub75_top.sv
// hub75_top: 64x64 1/32-scan HUB75 panel driver with built-in test pattern; `define PATTERN_ANIM_EN scrolls the upper half.
module hub75_top #(
  parameter int COLS = 64,
  parameter int SCAN_ROWS = 32,
  localparam int CW = $clog2(COLS),
  localparam int AW = $clog2(SCAN_ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [1:0]    r,
  output logic [1:0]    g,
  output logic [1:0]    b,
  output logic          latch,
  output logic          blank,
  output logic          led_clk,
  output logic [AW-1:0] addr
);
  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, UNBLANK} state_t;
  state_t        state;
  logic [CW-1:0] col;
  logic [CW-1:0] x;
  logic [AW-1:0] row;
  logic          ph;
  logic          first;
`ifdef PATTERN_ANIM_EN
  logic [CW-1:0] frame;
  assign x = col + frame;
  always_ff @(posedge clk)
    if (rst) frame <= '0;
    else if (state == UNBLANK && row == AW'(SCAN_ROWS - 1)) frame <= frame + CW'(1);
`else
  assign x = col;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      ph    <= 1'b0;
      first <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= SHIFT;
          col   <= '0;
          ph    <= 1'b0;
          first <= 1'b1;
        end
        SHIFT: begin
          ph <= ~ph;
          if (ph) begin
            if (col == CW'(COLS - 1)) state <= BLANK;
            else col <= col + CW'(1);
          end
        end
        BLANK: state <= LATCH;
        LATCH: state <= UNBLANK;
        UNBLANK: begin
          row   <= row == AW'(SCAN_ROWS - 1) ? '0 : row + AW'(1);
          col   <= '0;
          ph    <= 1'b0;
          first <= 1'b0;
          state <= start ? SHIFT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  // Output stage is a registered image of the sequencer state, so start never reaches a pin combinationally.
  always_ff @(posedge clk)
    if (rst) begin
      r       <= '0;
      g       <= '0;
      b       <= '0;
      latch   <= 1'b0;
      blank   <= 1'b1;
      led_clk <= 1'b0;
      addr    <= '0;
    end else begin
      r       <= state == SHIFT ? {row[2], x[3]} : 2'b00;
      g       <= state == SHIFT ? {row[3], x[4]} : 2'b00;
      b       <= state == SHIFT ? {row[4], x[5]} : 2'b00;
      led_clk <= state == SHIFT && ph;
      latch   <= state == LATCH;
      blank   <= state == SHIFT ? first : state != UNBLANK;
      addr    <= state == LATCH ? row : addr;
    end
endmodule

// File: tb/tb_hub75_top.sv
// tb_hub75_top: randomized self-checking bench for hub75_top against a row-timeline reference model.
module tb_hub75_top;
  logic clk = 1'b0;
  logic rst, start;
  logic [1:0] r, g, b;
  logic latch, blank, led_clk;
  logic [4:0] addr;
  logic [13:0] obs;
  int errors = 0;
  int checks = 0;
  int mk, my, ma, mframe;
  logic mfirst, mcont;

  hub75_top dut (.clk(clk), .rst(rst), .start(start), .r(r), .g(g), .b(b),
                 .latch(latch), .blank(blank), .led_clk(led_clk), .addr(addr));

  always #5 clk = ~clk;
  assign obs = {r, g, b, latch, blank, led_clk, addr};

  // mk is the position of the current output cycle within a 131-cycle row: -1/0 idle, 1..128 shift, 129 blank, 130 latch, 131 unblank
  task automatic model_reset();
    mk = -1; my = 0; ma = 0; mframe = 0; mfirst = 1'b0; mcont = 1'b0;
  endtask

  task automatic model_step(input logic s);
    if (mk == -1) mk = s ? 0 : -1;
    else if (mk < 130) mk = mk + 1;
    else if (mk == 130) begin mk = 131; mcont = s; end
    else begin
`ifdef PATTERN_ANIM_EN
      if (my == 31) mframe = (mframe + 1) % 64;
`endif
      my = (my + 1) % 32;
      mfirst = 1'b0;
      mk = mcont ? 1 : (s ? 0 : -1);
    end
    if (mk == 0) mfirst = 1'b1;
    if (mk == 130) ma = my;
  endtask

  function automatic logic [13:0] exp_vec();
    logic [1:0] er, eg, eb;
    logic el, ebl, ec;
    int x;
    er = 2'b00; eg = 2'b00; eb = 2'b00; el = 1'b0; ebl = 1'b1; ec = 1'b0;
    if (mk >= 1 && mk <= 128) begin
      x = ((mk - 1) / 2 + mframe) % 64;
      ec = 1'((mk - 1) % 2);
      ebl = mfirst;
      er = {1'((my / 4) % 2), 1'((x / 8) % 2)};
      eg = {1'((my / 8) % 2), 1'((x / 16) % 2)};
      eb = {1'((my / 16) % 2), 1'((x / 32) % 2)};
    end else if (mk == 130) el = 1'b1;
    else if (mk == 131) ebl = 1'b0;
    return {er, eg, eb, el, ebl, ec, 5'(ma)};
  endfunction

  task automatic tick(input logic s, input logic rs);
    start = s; rst = rs;
    @(posedge clk); #1;
    if (rs) model_reset(); else model_step(s);
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b1);
    checks++;
    if (obs !== 14'b00_00_00_0_1_0_00000) begin errors++; $display("FAIL reset_vals got=%b exp=%b", obs, 14'b00_00_00_0_1_0_00000); end
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0);
      checks++;
      if (obs !== 14'b00_00_00_0_1_0_00000 || obs !== exp_vec()) begin errors++; $display("FAIL idle cyc=%0d got=%b exp=%b", i, obs, exp_vec()); end
    end
  endtask

  task automatic test_first_row();
    int lat_at, rises;
    logic pl;
    lat_at = -1; rises = 0;
    tick(1'b1, 1'b0);
    pl = led_clk;
    for (int n = 1; n <= 200 && lat_at < 0; n++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL row0 n=%0d got=%b exp=%b", n, obs, exp_vec()); end
      if (led_clk && !pl) rises++;
      pl = led_clk;
      if (latch) lat_at = n;
    end
    checks++;
    if (lat_at != 130) begin errors++; $display("FAIL latch_cycle got=%0d exp=130", lat_at); end
    checks++;
    if (rises != 64) begin errors++; $display("FAIL led_rises got=%0d exp=64", rises); end
    checks++;
    if (blank !== 1'b1) begin errors++; $display("FAIL blank_at_latch got=%b exp=1", blank); end
    tick(1'b1, 1'b0);
    checks++;
    if (latch !== 1'b0 || addr !== 5'd0) begin errors++; $display("FAIL after_latch latch=%b addr=%0d exp latch=0 addr=0", latch, addr); end
  endtask

  task automatic test_frame();
    int last_lat, nlat, paddr;
    logic pl, done5, wrapped;
    last_lat = -1; nlat = 0; paddr = 0; pl = led_clk; done5 = 1'b0; wrapped = 1'b0;
    for (int n = 0; n < 32 * 131 + 200; n++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL frame n=%0d got=%b exp=%b", n, obs, exp_vec()); end
      if (led_clk && !pl && my == 5 && (mk - 1) / 2 == 8 && !done5) begin
        done5 = 1'b1;
        checks++;
        if ({r[0], g[0], b[0], r[1], g[1], b[1]} !== 6'b100100) begin errors++; $display("FAIL row5_col8 got=%b exp=100100", {r[0], g[0], b[0], r[1], g[1], b[1]}); end
      end
      pl = led_clk;
      if (latch) begin
        nlat++;
        if (last_lat >= 0) begin
          checks++;
          if (n - last_lat != 131) begin errors++; $display("FAIL latch_spacing got=%0d exp=131", n - last_lat); end
        end
        checks++;
        if (addr !== 5'((paddr + 1) % 32)) begin errors++; $display("FAIL addr_step got=%0d exp=%0d", addr, (paddr + 1) % 32); end
        if (paddr == 31 && addr == 5'd0) wrapped = 1'b1;
        paddr = int'(addr);
        last_lat = n;
      end
    end
    checks++;
    if (nlat < 33 || !wrapped || !done5) begin errors++; $display("FAIL frame_cover latches=%0d wrapped=%b row5=%b exp >=33,1,1", nlat, wrapped, done5); end
  endtask

  task automatic test_stop();
    int nlat, lat_addr, post;
    logic pl, found, seen;
    found = 1'b0; nlat = 0; lat_addr = -1; post = 0; seen = 1'b0;
    tick(1'b0, 1'b1);
    for (int n = 0; n < 1000 && !found; n++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL stop_run n=%0d got=%b exp=%b", n, obs, exp_vec()); end
      found = my == 3 && mk == 41;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL stop_reach got=not_reached exp=row3_col20"); end
    pl = led_clk;
    for (int n = 0; n < 300; n++) begin
      tick(1'b0, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL stop n=%0d got=%b exp=%b", n, obs, exp_vec()); end
      if (seen && led_clk && !pl) post++;
      pl = led_clk;
      if (latch) begin nlat++; lat_addr = int'(addr); seen = 1'b1; end
    end
    checks++;
    if (nlat != 1 || lat_addr != 3) begin errors++; $display("FAIL stop_latch count=%0d addr=%0d exp count=1 addr=3", nlat, lat_addr); end
    checks++;
    if (post != 0 || blank !== 1'b1) begin errors++; $display("FAIL stop_idle rises=%0d blank=%b exp rises=0 blank=1", post, blank); end
  endtask

  task automatic test_reset_mid();
    logic got_rise, got_lat, pl;
    got_rise = 1'b0; got_lat = 1'b0;
    tick(1'b0, 1'b1);
    for (int n = 0; n < 50; n++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    checks++;
    if (obs !== 14'b00_00_00_0_1_0_00000) begin errors++; $display("FAIL reset_mid got=%b exp=%b", obs, 14'b00_00_00_0_1_0_00000); end
    pl = led_clk;
    for (int n = 0; n < 200; n++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL restart n=%0d got=%b exp=%b", n, obs, exp_vec()); end
      if (led_clk && !pl && !got_rise) begin
        got_rise = 1'b1;
        checks++;
        if ({r, g, b} !== 6'b0) begin errors++; $display("FAIL restart_px0 got=%b exp=000000", {r, g, b}); end
      end
      pl = led_clk;
      if (latch && !got_lat) begin
        got_lat = 1'b1;
        checks++;
        if (addr !== 5'd0) begin errors++; $display("FAIL restart_addr got=%0d exp=0", addr); end
      end
    end
  endtask

  task automatic test_random();
    logic s;
    s = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) s = ~s;
      tick(s, $urandom_range(0, 1499) == 0);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL random n=%0d got=%b exp=%b", n, obs, exp_vec()); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    model_reset();
    test_reset();
    test_first_row();
    test_frame();
    test_stop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
